// File: rtl/uart_pkg.sv
// Shared types and helpers for the fabric-side UART receiver (uart_rx_sniffer).
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } rx_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

   function automatic int half_bit(input int clk_freq, input int baud);
      return clks_per_bit(clk_freq, baud) / 2;
   endfunction

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Value of the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with level output and same-cycle push/pop.
// A push into a full FIFO without a simultaneous pop is dropped and flagged on drop.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [WIDTH-1:0]              wdata,
   input  logic                          pop,
   output logic [WIDTH-1:0]              rdata,
   output logic                          valid,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          drop
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             full_s;
   logic             empty_s;
   logic             pop_s;
   logic             wr_en_s;

   // Handshake qualification: a pop frees the slot a full-FIFO push needs.
   always_comb begin
      full_s  = (count_r == FULL_CNT);
      empty_s = (count_r == {(AW + 1){1'b0}});
      pop_s   = pop & ~empty_s;
      wr_en_s = push & (~full_s | pop_s);
      drop    = push & full_s & ~pop_s;
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW + 1){1'b0}};
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (wr_en_s && !pop_s) begin
            count_r <= count_r + CNT_ONE;
         end else if (pop_s && !wr_en_s) begin
            count_r <= count_r - CNT_ONE;
         end else begin
            count_r <= count_r;
         end
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign valid = ~empty_s;
   assign level = count_r;

endmodule

// File: rtl/uart_rx_sniffer.sv
// 8N1 UART receiver feeding a byte FIFO with a valid/ready output stream.
// Define UART_RX_PARITY_EN for 9-bit framing with an even-parity bit after bit 7.
module uart_rx_sniffer
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               rxd,
   output logic [7:0]                         m_data,
   output logic                               m_valid,
   input  logic                               m_ready,
   output logic                               frame_err,
   output logic                               overrun,
   output logic                               parity_err,
   output logic [level_width(FIFO_DEPTH)-1:0] level
);
   localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
   localparam int HALF = half_bit(CLK_FREQ, BAUD);
   localparam int TW   = $clog2(CPB);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CPB - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
   localparam logic [TW-1:0] T_ONE     = TW'(1);

   rx_state_t     state_r, state_s;
   logic [TW-1:0] timer_r, timer_s;
   logic [2:0]    bit_idx_r, bit_idx_s;
   logic [7:0]    shift_r, shift_s;
   logic          sync1_r;
   logic          rxd_s;
   logic          bit_done_s;
   logic          push_s;
   logic          ferr_s;
   logic          perr_s;
   logic          drop_s;
   logic          frame_err_r;
   logic          overrun_r;
   logic          parity_err_r;
`ifdef UART_RX_PARITY_EN
   logic          par_bad_r, par_bad_s;
`endif

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b1;
         rxd_s   <= 1'b1;
      end else begin
         sync1_r <= rxd;
         rxd_s   <= sync1_r;
      end
   end

   // Frame sequencing: every sample point is a count of cycles since the previous one.
   always_comb begin
      state_s    = state_r;
      timer_s    = timer_r + T_ONE;
      bit_idx_s  = bit_idx_r;
      shift_s    = shift_r;
      push_s     = 1'b0;
      ferr_s     = 1'b0;
      perr_s     = 1'b0;
      bit_done_s = (timer_r == BIT_LAST);
`ifdef UART_RX_PARITY_EN
      par_bad_s  = par_bad_r;
`endif
      case (state_r)
         ST_IDLE: begin
            timer_s = {TW{1'b0}};
            if (!rxd_s) state_s = ST_START;
            else        state_s = ST_IDLE;
         end
         ST_START: begin
            if (timer_r == HALF_LAST) begin
               timer_s   = {TW{1'b0}};
               bit_idx_s = 3'd0;
               if (rxd_s) state_s = ST_IDLE;
               else        state_s = ST_DATA;
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_done_s) begin
               timer_s   = {TW{1'b0}};
               shift_s   = {rxd_s, shift_r[7:1]};
               bit_idx_s = bit_idx_r + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bit_idx_r == 3'd7) state_s = ST_PARITY;
               else                   state_s = ST_DATA;
`else
               if (bit_idx_r == 3'd7) state_s = ST_STOP;
               else                   state_s = ST_DATA;
`endif
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (bit_done_s) begin
               timer_s   = {TW{1'b0}};
               par_bad_s = rxd_s ^ even_parity(shift_r);
               state_s   = ST_STOP;
            end else begin
               state_s = ST_PARITY;
            end
`else
            state_s = ST_IDLE;
`endif
         end
         ST_STOP: begin
            if (bit_done_s) begin
               timer_s = {TW{1'b0}};
`ifdef UART_RX_PARITY_EN
               perr_s  = par_bad_r;
`endif
               if (rxd_s) begin
                  push_s  = ~perr_s;
                  state_s = ST_IDLE;
               end else begin
                  ferr_s  = 1'b1;
                  state_s = ST_WAIT_IDLE;
               end
            end else begin
               state_s = ST_STOP;
            end
         end
         ST_WAIT_IDLE: begin
            timer_s = {TW{1'b0}};
            if (rxd_s) state_s = ST_IDLE;
            else       state_s = ST_WAIT_IDLE;
         end
         default: begin
            timer_s = {TW{1'b0}};
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and registered error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         timer_r      <= {TW{1'b0}};
         bit_idx_r    <= 3'd0;
         shift_r      <= 8'h00;
         frame_err_r  <= 1'b0;
         overrun_r    <= 1'b0;
         parity_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_r    <= 1'b0;
`endif
      end else begin
         state_r      <= state_s;
         timer_r      <= timer_s;
         bit_idx_r    <= bit_idx_s;
         shift_r      <= shift_s;
         frame_err_r  <= ferr_s;
         overrun_r    <= drop_s;
         parity_err_r <= perr_s;
`ifdef UART_RX_PARITY_EN
         par_bad_r    <= par_bad_s;
`endif
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .wdata (shift_r),
      .pop   (m_ready),
      .rdata (m_data),
      .valid (m_valid),
      .level (level),
      .drop  (drop_s)
   );

   assign frame_err  = frame_err_r;
   assign overrun    = overrun_r;
   assign parity_err = parity_err_r;

endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Randomized bench for uart_rx_sniffer checked against a queue-based byte model.
// Build with UART_RX_PARITY_EN defined to exercise the 9-bit parity framing.
module tb_uart_rx_sniffer;
   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 2_000_000;
   localparam int DEPTH    = 16;
   localparam int CPB      = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN   = 1'b1;
   localparam int NBITS    = 11;
`else
   localparam bit PAR_EN   = 1'b0;
   localparam int NBITS    = 10;
`endif
   localparam int LATENCY  = 2 + HALF + (NBITS - 1) * CPB + 1;

   logic       clk;
   logic       rst;
   logic       rxd;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;
   logic [4:0] level;

   int         n_tests, n_fail;
   int         exp_ferr, exp_ovr, exp_perr;
   int         obs_ferr, obs_ovr, obs_perr;
   int         model_occ;
   bit         rand_rdy;
   logic [7:0] exp_q[$];

   uart_rx_sniffer #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err),
      .level      (level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction

   // Consumer side of the model: every accepted byte must be the oldest expected one.
   initial begin
      logic prev_ferr, prev_ovr, prev_perr;
      prev_ferr = 1'b0; prev_ovr = 1'b0; prev_perr = 1'b0;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  check_eq("unexpected_byte", 32'(m_valid), 32'd0);
               end else begin
                  check_eq("rx_byte", 32'(m_data), 32'(exp_q.pop_front()));
                  model_occ--;
               end
            end
            if (frame_err) begin obs_ferr++; check_eq("ferr_width", 32'(prev_ferr), 32'd0); end
            if (overrun)   begin obs_ovr++;  check_eq("ovr_width",  32'(prev_ovr),  32'd0); end
            if (parity_err) begin obs_perr++; check_eq("perr_width", 32'(prev_perr), 32'd0); end
            prev_ferr = frame_err; prev_ovr = overrun; prev_perr = parity_err;
         end else begin
            prev_ferr = 1'b0; prev_ovr = 1'b0; prev_perr = 1'b0;
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic drive_bit(input logic v);
      rxd = v;
      idle(CPB);
   endtask

   // Producer side of the model: decide the frame's fate from the framing rules, then send it.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      logic good;
      good = stop;
      if (PAR_EN && (par != even_par(d))) begin
         good = 1'b0;
         exp_perr++;
      end
      if (!stop) exp_ferr++;
      if (good) begin
         if (model_occ >= DEPTH && !m_ready) begin
            exp_ovr++;
         end else begin
            exp_q.push_back(d);
            model_occ++;
         end
      end
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par);
`endif
      drive_bit(stop);
   endtask

   task automatic check_counts();
      check_eq("frame_err_cnt", obs_ferr, exp_ferr);
      check_eq("overrun_cnt", obs_ovr, exp_ovr);
      check_eq("parity_err_cnt", obs_perr, exp_perr);
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_m_data", 32'(m_data), 32'd0);
      check_eq("rst_level", 32'(level), 32'd0);
      check_eq("rst_frame_err", 32'(frame_err), 32'd0);
      check_eq("rst_overrun", 32'(overrun), 32'd0);
      check_eq("rst_parity_err", 32'(parity_err), 32'd0);
   endtask

   task automatic drain(input string tag);
      m_ready = 1'b1;
      for (int i = 0; i < 4 * DEPTH && (exp_q.size() != 0 || level != 5'd0); i++) @(negedge clk);
      check_eq({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
      check_eq({tag, "_level"}, 32'(level), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int         lat;
      logic       seen;
      logic [7:0] d;
      logic       stop, bad;
      n_tests = 0; n_fail = 0;
      exp_ferr = 0; exp_ovr = 0; exp_perr = 0;
      obs_ferr = 0; obs_ovr = 0; obs_perr = 0;
      model_occ = 0; rand_rdy = 1'b0;
      rst = 1'b1; rxd = 1'b1; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;

      // Single byte: latency from the falling edge and a one-cycle m_valid.
      m_ready = 1'b1;
      fork
         send_frame(8'hA5, even_par(8'hA5), 1'b1);
         begin
            lat = 0; seen = 1'b0;
            while (!seen && lat < 2 * LATENCY) begin
               @(posedge clk); lat++;
               @(negedge clk); seen = m_valid;
            end
            check_eq("latency", lat, LATENCY);
            @(negedge clk);
            check_eq("valid_one_cycle", 32'(m_valid), 32'd0);
         end
      join
      idle(CPB);
      check_counts();

      // Short low glitch on an idle line is rejected silently.
      rxd = 1'b0;
      idle(HALF / 2);
      rxd = 1'b1;
      idle(3 * CPB);
      check_eq("glitch_level", 32'(level), 32'd0);
      check_counts();

      // Bad stop bit followed by a break; nothing is accepted until the line idles.
      send_frame(8'h3C, even_par(8'h3C), 1'b0);
      idle(10 * CPB);
      check_eq("break_level", 32'(level), 32'd0);
      check_counts();
      rxd = 1'b1;
      idle(CPB);
      send_frame(8'h11, even_par(8'h11), 1'b1);
      idle(2 * CPB);
      check_eq("after_break_queue", 32'(exp_q.size()), 32'd0);
      check_counts();

      // Fill with the consumer stalled; the seventeenth byte overruns.
      m_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         d = 8'(i);
         send_frame(d, even_par(d), 1'b1);
      end
      idle(2 * CPB);
      check_eq("full_level", 32'(level), 32'(DEPTH));
      check_counts();
      drain("overrun_drain");

      // Reset in the middle of data bit 4 wipes the FIFO and the partial frame.
      m_ready = 1'b0;
      send_frame(8'h5A, even_par(8'h5A), 1'b1);
      idle(2 * CPB);
      check_eq("pre_rst_level", 32'(level), 32'd1);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      idle(HALF);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      exp_q.delete();
      model_occ = 0;
      idle(5 * CPB);
      m_ready = 1'b1;
      send_frame(8'h55, even_par(8'h55), 1'b1);
      idle(2 * CPB);
      check_eq("after_rst_queue", 32'(exp_q.size()), 32'd0);
      check_counts();

`ifdef UART_RX_PARITY_EN
      // Wrong then right parity on the same byte.
      send_frame(8'h07, 1'b0, 1'b1);
      idle(2 * CPB);
      check_eq("bad_parity_level", 32'(level), 32'd0);
      check_counts();
      send_frame(8'h07, 1'b1, 1'b1);
      idle(2 * CPB);
      check_eq("good_parity_queue", 32'(exp_q.size()), 32'd0);
      check_counts();
`endif

      // Random bytes, random stop/parity faults and a randomly stalling consumer.
      rand_rdy = 1'b1;
      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         bad  = PAR_EN && ($urandom_range(0, 4) == 0);
         send_frame(d, even_par(d) ^ bad, stop);
         if (!stop) idle($urandom_range(0, 2 * CPB));
         rxd = 1'b1;
         idle(CPB + $urandom_range(0, CPB));
      end
      rand_rdy = 1'b0;
      drain("random_drain");
      check_counts();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
